// File: rtl/icache_dm_pkg.sv
// ============================================================================
// Module : icache_dm_pkg
// Brief  : Shared types and constants for the direct-mapped instruction cache.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package icache_dm_pkg;

  localparam int ICACHE_SETS   = 16;
  localparam int ICACHE_WORD_W = 32;
  localparam int ICACHE_IDX_W  = $clog2(ICACHE_SETS);
  localparam int ICACHE_TAG_W  = ICACHE_WORD_W - ICACHE_IDX_W - 2;

  typedef struct packed {
    logic [ICACHE_TAG_W-1:0] tag;
    logic [ICACHE_IDX_W-1:0] idx;
    logic [1:0]              bytoff;
  } icachef_t;

  typedef struct packed {
    logic                     valid;
    logic [ICACHE_TAG_W-1:0]  tag;
    logic [ICACHE_WORD_W-1:0] data;
  } icache_frame_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } icache_state_t;

  // Performance counters stick at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/icache_dm_if.sv
// ============================================================================
// Module : icache_dm_if
// Brief  : Datapath fetch port, memory read port and counters of the I-cache.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface icache_dm_if
  import icache_dm_pkg::*;
#(
  parameter int WORD_W = ICACHE_WORD_W
) ();

  logic              imemREN;
  logic [WORD_W-1:0] imemaddr;
  logic              ihit;
  logic [WORD_W-1:0] imemload;
  logic              flush;
  logic              iREN;
  logic [WORD_W-1:0] iaddr;
  logic [WORD_W-1:0] iload;
  logic              iwait;
  logic [31:0]       hit_cnt;
  logic [31:0]       miss_cnt;

  modport master (
    output imemREN, imemaddr, flush, iload, iwait,
    input  ihit, imemload, iREN, iaddr, hit_cnt, miss_cnt
  );

  modport slave (
    input  imemREN, imemaddr, flush, iload, iwait,
    output ihit, imemload, iREN, iaddr, hit_cnt, miss_cnt
  );

endinterface

`default_nettype wire

// File: rtl/icache_dm.sv
// ============================================================================
// Module : icache_dm
// Brief  : Direct-mapped read-only instruction cache, 0-cycle hits, one-word fills.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module icache_dm
  import icache_dm_pkg::*;
#(
  parameter int SETS   = ICACHE_SETS,
  parameter int WORD_W = ICACHE_WORD_W
) (
  input  logic       CLK,
  input  logic       RST,
  icache_dm_if.slave bus
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = WORD_W - IDX_W - 2;

  icache_state_t     state;
  icache_state_t     state_next;
  logic [SETS-1:0]   valid;
  logic [TAG_W-1:0]  tags [SETS];
  logic [WORD_W-1:0] data [SETS];
  logic [WORD_W-1:0] miss_addr;
  logic [31:0]       hit_cnt;
  logic [31:0]       miss_cnt;

  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  fill_idx;
  logic [TAG_W-1:0]  fill_tag;
  logic              lookup_hit;
  logic              hit;
  logic              miss;
  logic              fill;
  logic              unused_bytoff;

  assign req_idx       = bus.imemaddr[IDX_W+1:2];
  assign req_tag       = bus.imemaddr[WORD_W-1:IDX_W+2];
  assign fill_idx      = miss_addr[IDX_W+1:2];
  assign fill_tag      = miss_addr[WORD_W-1:IDX_W+2];
  assign unused_bytoff = ^bus.imemaddr[1:0];

  assign bus.hit_cnt   = hit_cnt;
  assign bus.miss_cnt  = miss_cnt;

  always_comb begin
    lookup_hit   = 1'b0;
    hit          = 1'b0;
    miss         = 1'b0;
    fill         = 1'b0;
    state_next   = state;
    bus.ihit     = 1'b0;
    bus.imemload = '0;
    bus.iREN     = 1'b0;
    bus.iaddr    = '0;

    case (state)
      IDLE: begin
        lookup_hit = bus.imemREN && valid[req_idx] && (tags[req_idx] == req_tag);
        hit        = lookup_hit && !bus.flush;
        miss       = bus.imemREN && !lookup_hit && !bus.flush;
        if (hit) begin
          bus.ihit     = 1'b1;
          bus.imemload = data[req_idx];
        end
        if (miss) begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        bus.iREN  = 1'b1;
        bus.iaddr = miss_addr;
        // A flush arriving with the data abandons the fill.
        fill      = !bus.iwait && !bus.flush;
        if (!bus.iwait) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    if (bus.flush) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      valid     <= '0;
      miss_addr <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
    end else begin
      state <= state_next;
      if (bus.flush) begin
        valid <= '0;
      end else if (fill) begin
        valid[fill_idx] <= 1'b1;
      end
      if (miss) begin
        miss_addr <= {bus.imemaddr[WORD_W-1:2], 2'b00};
        miss_cnt  <= sat_inc(miss_cnt);
      end
      if (hit) begin
        hit_cnt <= sat_inc(hit_cnt);
      end
    end
  end

  // Tag and data need no reset: they are only observed behind the valid bit.
  always_ff @(posedge CLK) begin
    if (fill && !RST) begin
      tags[fill_idx] <= fill_tag;
      data[fill_idx] <= bus.iload;
    end
  end

endmodule

`default_nettype wire
